// File: rtl/regfile_pkg.sv
// Shared constants, entry type and load-extension helper for the write-back arbiter.
package regfile_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned AW   = 5;

    localparam logic [5:0] OP_LWZ = 6'd32;
    localparam logic [5:0] OP_LBZ = 6'd34;
    localparam logic [5:0] OP_LHZ = 6'd40;
    localparam logic [5:0] OP_LHA = 6'd42;
    localparam logic [5:0] OP_LD  = 6'd48;

    // Round-robin preference: which port wins when both heads are valid.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_t;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [5:0]      op;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    function automatic logic op_known(input logic [5:0] opcode);
        return (opcode == OP_LWZ) || (opcode == OP_LBZ) || (opcode == OP_LHZ) ||
               (opcode == OP_LHA) || (opcode == OP_LD);
    endfunction

    function automatic logic [XLEN-1:0] ext_load(input logic [5:0] opcode,
                                                 input logic [XLEN-1:0] data);
        case (opcode)
            OP_LWZ:  return {{(XLEN-32){1'b0}}, data[31:0]};
            OP_LBZ:  return {{(XLEN-8){1'b0}}, data[7:0]};
            OP_LHZ:  return {{(XLEN-16){1'b0}}, data[15:0]};
            OP_LHA:  return {{(XLEN-16){data[15]}}, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-producer write-back FIFO; also reports which registers it holds.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [AW-1:0]   in_rd,
    input  logic [5:0]      in_op,
    input  logic [XLEN-1:0] in_data,
    output logic            empty,
    output logic            full,
    output logic [AW-1:0]   head_rd,
    output logic [5:0]      head_op,
    output logic [XLEN-1:0] head_data,
    output logic [31:0]     rd_mask
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_ent_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign head_rd   = mem[head].rd;
    assign head_op   = mem[head].op;
    assign head_data = mem[head].data;

    // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                mem[tail] <= '{rd: in_rd, op: in_op, data: in_data};
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // One-hot OR of destination registers over occupied slots.
    always_comb begin
        rd_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i]) rd_mask[mem[i].rd] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU and LSU.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [5:0]      lsu_opcode,
    input  logic [XLEN-1:0] lsu_data,
    output logic            wb_en,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     pend_mask,
    output logic            bad_op
);

    logic            alu_empty, alu_full, lsu_empty, lsu_full;
    logic [AW-1:0]   alu_hrd, lsu_hrd;
    logic [5:0]      alu_hop, lsu_hop;
    logic [XLEN-1:0] alu_hdata, lsu_hdata;
    logic [31:0]     alu_mask, lsu_mask;

    rr_t             rr;
    logic            grant_alu, grant_lsu;
    logic [AW-1:0]   win_rd;
    logic [5:0]      win_op;
    logic [XLEN-1:0] win_data;
    logic [AW-1:0]   bad_rd;

    assign alu_ready = !alu_full;
    assign lsu_ready = !lsu_full;

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_valid && alu_ready),
        .pop       (grant_alu),
        .in_rd     (alu_rd),
        .in_op     (OP_LD),
        .in_data   (alu_data),
        .empty     (alu_empty),
        .full      (alu_full),
        .head_rd   (alu_hrd),
        .head_op   (alu_hop),
        .head_data (alu_hdata),
        .rd_mask   (alu_mask)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lsu_valid && lsu_ready),
        .pop       (grant_lsu),
        .in_rd     (lsu_rd),
        .in_op     (lsu_opcode),
        .in_data   (lsu_data),
        .empty     (lsu_empty),
        .full      (lsu_full),
        .head_rd   (lsu_hrd),
        .head_op   (lsu_hop),
        .head_data (lsu_hdata),
        .rd_mask   (lsu_mask)
    );

    // Grant selection from FIFO heads and winner mux.
    always_comb begin
        grant_alu = !alu_empty && (lsu_empty || (rr == RR_ALU));
        grant_lsu = !lsu_empty && !grant_alu;
        win_rd    = grant_alu ? alu_hrd   : lsu_hrd;
        win_op    = grant_alu ? alu_hop   : lsu_hop;
        win_data  = grant_alu ? alu_hdata : lsu_hdata;
    end

    // Round-robin pointer moves only when something is granted.
    always_ff @(posedge clk) begin
        if (rst)            rr <= RR_ALU;
        else if (grant_alu) rr <= RR_LSU;
        else if (grant_lsu) rr <= RR_ALU;
    end

    // Registered write port; an unknown LSU opcode consumes its slot as a bad_op pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            bad_op  <= 1'b0;
            bad_rd  <= '0;
        end else begin
            wb_en  <= 1'b0;
            bad_op <= 1'b0;
            if (grant_alu || grant_lsu) begin
                if (op_known(win_op)) begin
                    wb_en   <= 1'b1;
                    wb_addr <= win_rd;
                    wb_data <= ext_load(win_op, win_data);
                end else begin
                    bad_op <= 1'b1;
                    bad_rd <= win_rd;
                end
            end
        end
    end

    // Pending registers: both queues plus whatever the output stage is presenting.
    always_comb begin
        pend_mask = alu_mask | lsu_mask;
        if (wb_en)  pend_mask[wb_addr] = 1'b1;
        if (bad_op) pend_mask[bad_rd]  = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: queue-based reference model plus directed vectors.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd = '0, lsu_rd = '0;
    logic [5:0]  lsu_opcode = '0;
    logic [63:0] alu_data = '0, lsu_data = '0;
    logic        wb_en, bad_op;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [31:0] pend_mask;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_opcode (lsu_opcode),
        .lsu_data   (lsu_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .pend_mask  (pend_mask),
        .bad_op     (bad_op)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          lsu;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [63:0] d;
    } req_t;

    // ---------------- stimulus drivers ----------------
    req_t dq_alu[$];
    req_t dq_lsu[$];
    bit   a_acc, l_acc;

    always @(negedge clk) begin
        a_acc = alu_valid && alu_ready;
        l_acc = lsu_valid && lsu_ready;
    end

    always @(posedge clk) begin
        #1;
        if (a_acc && dq_alu.size() > 0) void'(dq_alu.pop_front());
        if (l_acc && dq_lsu.size() > 0) void'(dq_lsu.pop_front());
        a_acc = 1'b0;
        l_acc = 1'b0;
        if (dq_alu.size() > 0) begin
            alu_valid = 1'b1; alu_rd = dq_alu[0].rd; alu_data = dq_alu[0].d;
        end else alu_valid = 1'b0;
        if (dq_lsu.size() > 0) begin
            lsu_valid = 1'b1; lsu_rd = dq_lsu[0].rd; lsu_opcode = dq_lsu[0].op; lsu_data = dq_lsu[0].d;
        end else lsu_valid = 1'b0;
    end

    // ---------------- reference model ----------------
    req_t        mq_alu[$];
    req_t        mq_lsu[$];
    bit          live = 1'b0;
    bit          m_pref_alu, m_en, m_bad, m_got, m_ok, m_a_room, m_l_room;
    logic [4:0]  m_addr, m_bad_rd;
    logic [63:0] m_data, m_r;
    req_t        m_w;

    function automatic bit m_ext(input logic [5:0] op, input logic [63:0] d, output logic [63:0] r);
        r = d;
        case (op)
            6'd32: r = d % (64'd1 << 32);
            6'd34: r = d % 64'd256;
            6'd40: r = d % 64'd65536;
            6'd42: begin
                r = d % 64'd65536;
                if (r >= 64'd32768) r = r - 64'd65536;
            end
            6'd48: r = d;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq_alu.delete(); mq_lsu.delete();
            m_en = 0; m_bad = 0; m_addr = '0; m_data = '0; m_bad_rd = '0;
            m_pref_alu = 1; live = 1;
        end else begin
            m_a_room = mq_alu.size() < DEPTH;
            m_l_room = mq_lsu.size() < DEPTH;
            m_en = 0; m_bad = 0; m_got = 0;
            if (mq_alu.size() > 0 && (mq_lsu.size() == 0 || m_pref_alu)) begin
                m_w = mq_alu.pop_front(); m_got = 1; m_pref_alu = 0;
            end else if (mq_lsu.size() > 0) begin
                m_w = mq_lsu.pop_front(); m_got = 1; m_pref_alu = 1;
            end
            if (m_got) begin
                if (!m_w.lsu) begin
                    m_en = 1; m_addr = m_w.rd; m_data = m_w.d;
                end else begin
                    m_ok = m_ext(m_w.op, m_w.d, m_r);
                    if (m_ok) begin m_en = 1; m_addr = m_w.rd; m_data = m_r; end
                    else begin m_bad = 1; m_bad_rd = m_w.rd; end
                end
            end
            if (alu_valid && m_a_room) mq_alu.push_back('{lsu: 1'b0, rd: alu_rd, op: 6'd0, d: alu_data});
            if (lsu_valid && m_l_room) mq_lsu.push_back('{lsu: 1'b1, rd: lsu_rd, op: lsu_opcode, d: lsu_data});
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] exp_mask;
    int          nwr = 0, a_low = 0, l_low = 0;

    always @(negedge clk) begin
        if (live) begin
            exp_mask = '0;
            foreach (mq_alu[i]) exp_mask[mq_alu[i].rd] = 1'b1;
            foreach (mq_lsu[i]) exp_mask[mq_lsu[i].rd] = 1'b1;
            if (m_en)  exp_mask[m_addr]   = 1'b1;
            if (m_bad) exp_mask[m_bad_rd] = 1'b1;
            chk("wb_en",     64'(wb_en),     64'(m_en));
            chk("wb_addr",   64'(wb_addr),   64'(m_addr));
            chk("wb_data",   wb_data,        m_data);
            chk("bad_op",    64'(bad_op),    64'(m_bad));
            chk("pend_mask", 64'(pend_mask), 64'(exp_mask));
            chk("alu_ready", 64'(alu_ready), 64'(mq_alu.size() < DEPTH));
            chk("lsu_ready", 64'(lsu_ready), 64'(mq_lsu.size() < DEPTH));
            if (wb_en) nwr++;
            if (!alu_ready) a_low++;
            if (!lsu_ready) l_low++;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_for(input bit want_bad, input int maxc, output int n);
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < maxc) begin
            @(negedge clk);
            n++;
            seen = want_bad ? bad_op : wb_en;
        end
        if (!seen) chk(want_bad ? "wait_bad_op_timeout" : "wait_wb_en_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wait_idle(input int maxc);
        int  n;
        bit  idle;
        n = 0;
        idle = 0;
        while (!idle && n < maxc) begin
            @(negedge clk);
            n++;
            idle = dq_alu.size() == 0 && dq_lsu.size() == 0 && !alu_valid && !lsu_valid &&
                   mq_alu.size() == 0 && mq_lsu.size() == 0 && !wb_en && !bad_op;
        end
        if (!idle) chk("idle_timeout", 64'(idle), 64'd1);
    endtask

    logic [4:0]  exp3 [8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    logic [63:0] exp2 [4] = '{64'hFFFFFFFFFFFF8001, 64'h00000000000000F0,
                              64'h00000000CCCCDDDD, 64'h0123456789ABCDEF};

    initial begin
        int n, w0, al0, ll0;
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, w0, al0, ll0;
        repeat (2) @(negedge clk);
        chk("rst_wb_en",     64'(wb_en),     64'd0);
        chk("rst_bad_op",    64'(bad_op),    64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("rst_pend",      64'(pend_mask), 64'd0);
        rst = 1'b0;

        // 1: single ALU write, 2-cycle latency, pend bit lifetime
        dq_alu.push_back('{lsu: 1'b0, rd: 5'd3, op: 6'd48, d: 64'hDEADBEEF00000001});
        wait_for(1'b0, 10, n);
        chk("t1_latency", 64'(n), 64'd3);
        chk("t1_addr", 64'(wb_addr), 64'd3);
        chk("t1_data", wb_data, 64'hDEADBEEF00000001);
        chk("t1_pend3", 64'(pend_mask[3]), 64'd1);
        @(negedge clk);
        chk("t1_en_off", 64'(wb_en), 64'd0);
        chk("t1_pend3_clr", 64'(pend_mask[3]), 64'd0);
        wait_idle(20);

        // 2: load extension
        dq_lsu.push_back('{lsu: 1'b1, rd: 5'd5, op: 6'd42, d: 64'h0000000000008001});
        dq_lsu.push_back('{lsu: 1'b1, rd: 5'd6, op: 6'd34, d: 64'h00000000000012F0});
        dq_lsu.push_back('{lsu: 1'b1, rd: 5'd7, op: 6'd32, d: 64'hAAAABBBBCCCCDDDD});
        dq_lsu.push_back('{lsu: 1'b1, rd: 5'd8, op: 6'd48, d: 64'h0123456789ABCDEF});
        wait_for(1'b0, 10, n);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("t2_en", 64'(wb_en), 64'd1);
            chk("t2_data", wb_data, exp2[i]);
        end
        wait_idle(20);

        // 3: contention, alternating grants starting with ALU
        for (int i = 0; i < 4; i++) begin
            dq_alu.push_back('{lsu: 1'b0, rd: 5'(1 + i), op: 6'd48, d: 64'h1000 + 64'(i)});
            dq_lsu.push_back('{lsu: 1'b1, rd: 5'(11 + i), op: 6'd48, d: 64'h2000 + 64'(i)});
        end
        wait_for(1'b0, 10, n);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("t3_en", 64'(wb_en), 64'd1);
            chk("t3_addr", 64'(wb_addr), 64'(exp3[i]));
        end
        wait_idle(20);

        // 4: sustained back-pressure, no loss or duplication
        w0 = nwr; al0 = a_low; ll0 = l_low;
        for (int i = 0; i < 6; i++) begin
            dq_alu.push_back('{lsu: 1'b0, rd: 5'(16 + i), op: 6'd48, d: {32'hA5A5A5A5, 32'(i * 7)}});
            dq_lsu.push_back('{lsu: 1'b1, rd: 5'(24 + i), op: (i % 2 == 0) ? 6'd40 : 6'd42,
                               d: 64'hFEDC_BA98_7654_0000 + 64'(i * 16'h3001)});
        end
        wait_idle(100);
        chk("t4_writes", 64'(nwr - w0), 64'd12);
        chk("t4_alu_bp", 64'(a_low > al0), 64'd1);
        chk("t4_lsu_bp", 64'(l_low > ll0), 64'd1);

        // 5: unknown opcode
        dq_lsu.push_back('{lsu: 1'b1, rd: 5'd9, op: 6'd7, d: 64'h55});
        wait_for(1'b1, 10, n);
        chk("t5_no_en", 64'(wb_en), 64'd0);
        chk("t5_pend9", 64'(pend_mask[9]), 64'd1);
        @(negedge clk);
        chk("t5_bad_clr", 64'(bad_op), 64'd0);
        chk("t5_pend9_clr", 64'(pend_mask[9]), 64'd0);
        wait_idle(20);

        // 6: reset under load
        for (int i = 0; i < 4; i++) begin
            dq_alu.push_back('{lsu: 1'b0, rd: 5'(20 + i), op: 6'd48, d: 64'(i)});
            dq_lsu.push_back('{lsu: 1'b1, rd: 5'(24 + i), op: 6'd48, d: 64'(i + 10)});
        end
        repeat (4) @(negedge clk);
        dq_alu.delete();
        dq_lsu.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_en", 64'(wb_en), 64'd0);
        chk("t6_alu_ready", 64'(alu_ready), 64'd1);
        chk("t6_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("t6_pend", 64'(pend_mask), 64'd0);
        rst = 1'b0;
        dq_alu.push_back('{lsu: 1'b0, rd: 5'd30, op: 6'd48, d: 64'h30});
        dq_lsu.push_back('{lsu: 1'b1, rd: 5'd31, op: 6'd48, d: 64'h31});
        wait_for(1'b0, 10, n);
        chk("t6_first_alu", 64'(wb_addr), 64'd30);
        wait_idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
